// File: rtl/flash_burst_reader.sv
// Burst-read engine: pipelined Wishbone reads into a credit-limited FIFO.
// Define FLASH_BURST_BYTESWAP_EN to byte-reverse each word before the FIFO.
module flash_burst_reader #(
    parameter int ADDR_WIDTH = 22,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [CNT_WIDTH-1:0]  i_count,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_ack,
    input  logic [31:0]           i_wb_data,
    output logic [31:0]           o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam int SW = PW + 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  remain_q;
    logic [OW-1:0]         outst_q, outst_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [31:0]           mem [FIFO_DEPTH];
    logic                  done_q, done_d;

    logic          in_bus, credit, accept, ack_ok, pop;
    logic          start_ok, abort_ok, not_empty;
    logic [SW-1:0] in_flight;
    logic [31:0]   wr_data;

`ifdef FLASH_BURST_BYTESWAP_EN
    assign wr_data = {i_wb_data[7:0], i_wb_data[15:8],
                      i_wb_data[23:16], i_wb_data[31:24]};
`else
    assign wr_data = i_wb_data;
`endif

    // Words already buffered plus words still owed by the slave
    assign in_flight = {1'b0, occ_q} + {1'b0, outst_q};
    assign credit    = in_flight < SW'(FIFO_DEPTH);

    assign in_bus    = (state_q == ISSUE) || (state_q == WAIT_ACK);
    assign not_empty = (occ_q != '0);
    assign abort_ok  = i_abort && (state_q != IDLE);
    assign start_ok  = i_start && (state_q == IDLE) && !i_abort;
    assign accept    = o_wb_stb && !i_wb_stall;
    assign ack_ok    = in_bus && i_wb_ack && !i_abort;
    assign pop       = not_empty && i_ready;

    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;
    assign o_wb_cyc  = in_bus;
    assign o_wb_stb  = (state_q == ISSUE) && credit;
    assign o_wb_we   = 1'b0;
    assign o_wb_addr = addr_q;
    assign o_valid   = not_empty;
    assign o_data    = not_empty ? mem[rptr_q] : '0;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (abort_ok) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (i_count == '0) done_d = 1'b1;
                        else               state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept && remain_q == CNT_WIDTH'(1))
                        state_d = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (outst_q == '0 || (outst_q == OW'(1) && ack_ok))
                        state_d = DRAIN;
                end
                DRAIN: begin
                    if (!not_empty || (occ_q == OW'(1) && pop)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (accept && !ack_ok)
            outst_d = outst_q + OW'(1);
        else if (!accept && ack_ok)
            outst_d = outst_q - OW'(1);
    end

    always_comb begin
        occ_d = occ_q;
        if (ack_ok && !pop)
            occ_d = occ_q + OW'(1);
        else if (!ack_ok && pop)
            occ_d = occ_q - OW'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            addr_q   <= '0;
            remain_q <= '0;
            outst_q  <= '0;
            occ_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (abort_ok) begin
                outst_q <= '0;
                occ_q   <= '0;
                wptr_q  <= '0;
                rptr_q  <= '0;
            end else begin
                if (start_ok) begin
                    addr_q   <= i_start_addr;
                    remain_q <= i_count;
                end else if (accept) begin
                    addr_q   <= addr_q + ADDR_WIDTH'(1);
                    remain_q <= remain_q - CNT_WIDTH'(1);
                end
                outst_q <= outst_d;
                occ_q   <= occ_d;
                if (ack_ok) wptr_q <= wptr_q + PW'(1);
                if (pop)    rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: o_data is masked while the FIFO is empty
    always_ff @(posedge i_clk) begin
        if (ack_ok) mem[wptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench for flash_burst_reader (FIFO_DEPTH=4).
// Table of bursts plus ready-backpressure, stall and abort sequences.
module tb_flash_burst_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [21:0] i_start_addr = '0;
    logic [15:0] i_count = '0;
    logic        i_abort = 1'b0;
    logic        o_busy, o_done, o_wb_cyc, o_wb_stb, o_wb_we;
    logic [21:0] o_wb_addr;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_ack = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b1;

    flash_burst_reader #(
        .ADDR_WIDTH(22),
        .CNT_WIDTH (16),
        .FIFO_DEPTH(4)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_start     (i_start),
        .i_start_addr(i_start_addr),
        .i_count     (i_count),
        .i_abort     (i_abort),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .o_wb_we     (o_wb_we),
        .o_wb_addr   (o_wb_addr),
        .i_wb_stall  (i_wb_stall),
        .i_wb_ack    (i_wb_ack),
        .i_wb_data   (i_wb_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] flash_word(input logic [21:0] a);
        if (a == 22'h000200) return 32'h11223344;
        return 32'hC000_0000 | {10'h0, a};
    endfunction

    function automatic logic [31:0] out_word(input logic [31:0] w);
`ifdef FLASH_BURST_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Monitor / slave state
    int          cyc_n = 0;
    logic [21:0] issued[$];
    logic [31:0] got[$];
    int          done_cnt, done_cyc, ack_cnt, last_ack_cyc;
    int          first_stb_cyc, last_iss_cyc, last_hs_cyc, cyc_fall;
    int          start_cyc;
    bit          stb_seen, cyc_seen;
    logic        nxt_ack = 1'b0;
    logic [21:0] nxt_addr = '0;

    task automatic clear_mon();
        issued.delete();
        got.delete();
        done_cnt = 0; done_cyc = -1; ack_cnt = 0; last_ack_cyc = -1;
        first_stb_cyc = -1; last_iss_cyc = -1; last_hs_cyc = -1;
        cyc_fall = -1; stb_seen = 0; cyc_seen = 0;
    endtask

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        nxt_ack  = o_wb_cyc && o_wb_stb && !i_wb_stall;
        nxt_addr = o_wb_addr;
        if (nxt_ack) begin
            issued.push_back(o_wb_addr);
            if (!stb_seen) first_stb_cyc = cyc_n;
            stb_seen = 1;
            last_iss_cyc = cyc_n;
        end
        if (i_wb_ack && o_wb_cyc) begin
            ack_cnt++;
            last_ack_cyc = cyc_n;
        end
        if (o_wb_cyc) cyc_seen = 1;
        else if (cyc_seen && cyc_fall < 0) cyc_fall = cyc_n;
        if (o_valid && i_ready) begin
            got.push_back(o_data);
            last_hs_cyc = cyc_n;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
    end

    // Pipelined slave: one-cycle ack for every accepted request
    always @(posedge clk) begin
        #1;
        i_wb_ack  = nxt_ack;
        i_wb_data = flash_word(nxt_addr);
    end

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
    endtask

    task automatic run_burst(input logic [21:0] a, input logic [15:0] n);
        @(posedge clk); #1;
        clear_mon();
        i_start = 1'b1; i_start_addr = a; i_count = n;
        start_cyc = cyc_n;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done(200);
    endtask

    task automatic check_words(input string tag, input logic [21:0] a,
                               input int n);
        logic [21:0] ea;
        check({tag, "_n_issued"}, issued.size(), n);
        check({tag, "_n_words"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            ea = a + 22'(i);
            check($sformatf("%s_addr%0d", tag, i),
                  i < issued.size() ? issued[i] : 64'hDEAD, ea);
            check($sformatf("%s_data%0d", tag, i),
                  i < got.size() ? got[i] : 64'hDEAD,
                  out_word(flash_word(ea)));
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    typedef struct {
        logic [21:0] addr;
        logic [15:0] count;
        logic [21:0] exp_last;
        logic [31:0] exp_d0;
    } vec_t;

    vec_t vec[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec[0] = '{22'h000100, 16'd4, 22'h000103,
`ifdef FLASH_BURST_BYTESWAP_EN
                   32'h000100C0};
`else
                   32'hC0000100};
`endif
        vec[1] = '{22'h3FFFFE, 16'd4, 22'h000001,
`ifdef FLASH_BURST_BYTESWAP_EN
                   32'hFEFF3FC0};
`else
                   32'hC03FFFFE};
`endif
        vec[2] = '{22'h000200, 16'd1, 22'h000200,
`ifdef FLASH_BURST_BYTESWAP_EN
                   32'h44332211};
`else
                   32'h11223344};
`endif
        vec[3] = '{22'h001000, 16'd0, 22'h0, 32'h0};
        vec[4] = '{22'h000010, 16'd7, 22'h000016,
`ifdef FLASH_BURST_BYTESWAP_EN
                   32'h100000C0};
`else
                   32'hC0000010};
`endif

        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_stb", o_wb_stb, 0);
        check("rst_we", o_wb_we, 0);
        check("rst_addr", o_wb_addr, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int r = 0; r < 5; r++) begin
            run_burst(vec[r].addr, vec[r].count);
            if (vec[r].count == 0) begin
                check($sformatf("v%0d_done_cnt", r), done_cnt, 1);
                check($sformatf("v%0d_done_lat", r), done_cyc, start_cyc + 1);
                check($sformatf("v%0d_cyc_idle", r), cyc_seen, 0);
                check($sformatf("v%0d_n_issued", r), issued.size(), 0);
            end else begin
                check_words($sformatf("v%0d", r), vec[r].addr, vec[r].count);
                check($sformatf("v%0d_last_addr", r),
                      issued.size() > 0 ? issued[issued.size()-1] : 64'hDEAD,
                      vec[r].exp_last);
                check($sformatf("v%0d_word0", r),
                      got.size() > 0 ? got[0] : 64'hDEAD, vec[r].exp_d0);
                check($sformatf("v%0d_first_stb", r), first_stb_cyc,
                      start_cyc + 1);
                check($sformatf("v%0d_issue_span", r),
                      last_iss_cyc - first_stb_cyc, vec[r].count - 1);
                check($sformatf("v%0d_done_lat", r), done_cyc,
                      last_hs_cyc + 1);
                check($sformatf("v%0d_cyc_fall", r), cyc_fall,
                      last_ack_cyc + 1);
            end
        end

        // Backpressure: credit must cap requests at FIFO_DEPTH
        @(posedge clk); #1;
        clear_mon();
        i_ready = 1'b0;
        i_start = 1'b1; i_start_addr = 22'h000400; i_count = 16'd10;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_n_issued_hold", issued.size(), 4);
        check("bp_stb_low", o_wb_stb, 0);
        check("bp_cyc_high", o_wb_cyc, 1);
        check("bp_valid", o_valid, 1);
        @(posedge clk); #1;
        i_ready = 1'b1;
        wait_done(300);
        check_words("bp", 22'h000400, 10);

        // Stall on the second request
        @(posedge clk); #1;
        clear_mon();
        i_start = 1'b1; i_start_addr = 22'h000800; i_count = 16'd3;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        i_wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("st_stb%0d", i), o_wb_stb, 1);
            check($sformatf("st_addr%0d", i), o_wb_addr, 22'h000801);
            @(posedge clk); #1;
        end
        i_wb_stall = 1'b0;
        wait_done(200);
        check_words("st", 22'h000800, 3);

        // Abort after two acks, then restart immediately
        @(posedge clk); #1;
        clear_mon();
        i_start = 1'b1; i_start_addr = 22'h000C00; i_count = 16'd8;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int i = 0; i < 50 && ack_cnt < 2; i++) @(posedge clk);
        check("ab_two_acks", ack_cnt >= 2, 1);
        #1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        i_start = 1'b1; i_start_addr = 22'h000D00; i_count = 16'd2;
        @(negedge clk);
        check("ab_cyc", o_wb_cyc, 0);
        check("ab_stb", o_wb_stb, 0);
        check("ab_valid", o_valid, 0);
        check("ab_busy", o_busy, 0);
        check("ab_no_done", done_cnt, 0);
        #1;
        clear_mon();
        start_cyc = cyc_n;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        check("ab_restart_busy", o_busy, 1);
        check("ab_restart_stb", o_wb_stb, 1);
        check("ab_restart_addr", o_wb_addr, 22'h000D00);
        wait_done(200);
        check_words("ab", 22'h000D00, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
